// File: rtl/ifu_pkg.sv
// ifu_pkg: shared IFU types and sizing for the instruction cache controller
// and the PLRU replacement block.
package ifu_pkg;

  localparam int IFU_ADDR_W     = 32;
  localparam int WAYS_NUM       = 16;
  localparam int WORDS_PER_LINE = 4;
  localparam int LINE_OFFSET_W  = 4;
  localparam int TAG_W          = IFU_ADDR_W - LINE_OFFSET_W;
  localparam int WAY_W          = $clog2(WAYS_NUM);
  localparam int WORD_IDX_W     = $clog2(WORDS_PER_LINE);

  typedef logic [WORDS_PER_LINE-1:0][31:0] t_line_data;

  // Control bundle consumed by the PLRU block
  typedef struct packed {
    logic             update_tree;
    logic             cache_miss;
    logic [WAY_W-1:0] hit_cl;
  } t_cache_ctrl_plru;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEM_REQ,
    MEM_FILL,
    REFILL
  } t_ifu_cache_state;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    t_line_data       data;
  } t_cache_line;

  // Counter increment that sticks at all-ones instead of wrapping
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ifu_cache_ctrl_if.sv
// ifu_cache_ctrl_if: fetch-side request/response and memory-side line fill
// signals of the IFU cache controller. 'slave' is the controller's view,
// 'master' is the view of the fetch stage plus memory around it.
interface ifu_cache_ctrl_if #(
  parameter int ADDR_W = ifu_pkg::IFU_ADDR_W
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic [31:0]       rsp_data;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_valid;
  logic [31:0]       mem_rsp_data;

  modport master (
    output req_valid, req_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  req_ready, rsp_valid, rsp_data, mem_req_valid, mem_req_addr
  );

  modport slave (
    input  req_valid, req_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output req_ready, rsp_valid, rsp_data, mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/ifu_tag_cmp.sv
// ifu_tag_cmp: parallel tag match across all ways of the fully associative
// cache. Reports hit, the matching way, and a multi-hit flag that must never
// assert in a correctly filled cache.
module ifu_tag_cmp
  import ifu_pkg::*;
#(
  parameter int TW = TAG_W,
  parameter int NW = WAYS_NUM,
  localparam int IW = $clog2(NW)
) (
  input  logic [NW-1:0]         valid,
  input  logic [NW-1:0][TW-1:0] tags,
  input  logic [TW-1:0]         tag,
  output logic                  hit,
  output logic [IW-1:0]         hit_way,
  output logic                  multi_hit
);

  logic [NW-1:0] match;

  // Match every way at once and encode the (single) matching index
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    match   = '0;
    hit_way = '0;
    for (int i = 0; i < NW; i++) begin
      match[i] = valid[i] && (tags[i] == tag);
      if (match[i]) hit_way = hit_way | IW'(i);
    end
    hit       = |match;
    multi_hit = (match & (match - NW'(1))) != '0;
  end

endmodule

// File: rtl/ifu_cache_ctrl.sv
// ifu_cache_ctrl: storage and control for the fully associative IFU
// instruction cache. Looks up one fetch at a time, refills missing lines from
// memory into the way chosen by the PLRU block, and drives the PLRU control.
// Optional build macro IFU_CACHE_PERF_EN adds saturating hit/miss counters.
module ifu_cache_ctrl
  import ifu_pkg::*;
#(
  parameter int ADDR_W = IFU_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  ifu_cache_ctrl_if.slave      bus,
  output t_cache_ctrl_plru     cache_ctrl_plru,
  input  logic [WAY_W-1:0]     evicted_cl
`ifdef IFU_CACHE_PERF_EN
  ,
  output logic [31:0]          perf_hit_cnt,
  output logic [31:0]          perf_miss_cnt
`endif
);

  localparam int CTAG_W = ADDR_W - LINE_OFFSET_W;

  t_ifu_cache_state                  state;
  logic [CTAG_W-1:0]                 tag_q;
  logic [WORD_IDX_W-1:0]             word_q;
  logic                              lookup_hit;
  logic [WORD_IDX_W-1:0]             beat_cnt;
  logic [WAYS_NUM-1:0]               valid_q;
  logic [WAYS_NUM-1:0][CTAG_W-1:0]   tag_arr;
  t_line_data                        data_arr [WAYS_NUM];
  t_line_data                        line_buf;

  logic [CTAG_W-1:0]     req_tag;
  logic [WORD_IDX_W-1:0] req_word;
  logic                  cmp_hit;
  logic                  cmp_multi;
  logic [WAY_W-1:0]      cmp_way;
  logic                  unused_addr_bits;

  assign req_tag          = bus.req_addr[ADDR_W-1:LINE_OFFSET_W];
  assign req_word         = bus.req_addr[LINE_OFFSET_W-1:2];
  assign unused_addr_bits = ^bus.req_addr[1:0];

  // The compare runs on the incoming address so the hit result is already
  // registered when LOOKUP starts; arrays cannot change between acceptance
  // and LOOKUP because they are written only in REFILL.
  ifu_tag_cmp #(
    .TW (CTAG_W),
    .NW (WAYS_NUM)
  ) u_tag_cmp (
    .valid     (valid_q),
    .tags      (tag_arr),
    .tag       (req_tag),
    .hit       (cmp_hit),
    .hit_way   (cmp_way),
    .multi_hit (cmp_multi)
  );

  // Control FSM with registered handshake, response and PLRU outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      valid_q           <= '0;
      tag_q             <= '0;
      word_q            <= '0;
      lookup_hit        <= 1'b0;
      beat_cnt          <= '0;
      bus.req_ready     <= 1'b1;
      bus.rsp_valid     <= 1'b0;
      bus.rsp_data      <= '0;
      bus.mem_req_valid <= 1'b0;
      bus.mem_req_addr  <= '0;
      cache_ctrl_plru   <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every branch sees the
      // values from before this edge; the pulses below default low each cycle.
      bus.rsp_valid   <= 1'b0;
      cache_ctrl_plru <= '0;
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            tag_q         <= req_tag;
            word_q        <= req_word;
            lookup_hit    <= cmp_hit;
            bus.req_ready <= 1'b0;
            state         <= LOOKUP;
            if (cmp_hit) begin
              bus.rsp_valid   <= 1'b1;
              bus.rsp_data    <= data_arr[cmp_way][req_word];
              cache_ctrl_plru <= '{update_tree: 1'b1, cache_miss: 1'b0, hit_cl: cmp_way};
            end
          end
        end
        LOOKUP: begin
          if (lookup_hit) begin
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end else begin
            bus.mem_req_valid <= 1'b1;
            bus.mem_req_addr  <= {tag_q, {LINE_OFFSET_W{1'b0}}};
            state             <= MEM_REQ;
          end
        end
        MEM_REQ: begin
          if (bus.mem_req_ready) begin
            bus.mem_req_valid <= 1'b0;
            state             <= MEM_FILL;
          end
        end
        MEM_FILL: begin
          if (bus.mem_rsp_valid) begin
            beat_cnt <= beat_cnt + WORD_IDX_W'(1);
            if (beat_cnt == WORD_IDX_W'(WORDS_PER_LINE - 1)) begin
              beat_cnt        <= '0;
              state           <= REFILL;
              bus.rsp_valid   <= 1'b1;
              // The requested word may be the beat arriving right now
              bus.rsp_data    <= (word_q == beat_cnt) ? bus.mem_rsp_data : line_buf[word_q];
              cache_ctrl_plru <= '{update_tree: 1'b1, cache_miss: 1'b1, hit_cl: '0};
            end
          end
        end
        REFILL: begin
          valid_q[evicted_cl] <= 1'b1;
          bus.req_ready       <= 1'b1;
          state               <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line buffer capture and tag/data array writes
  always_ff @(posedge clk) begin
    // NOTE: tag/data storage has no reset; valid_q alone decides whether a
    // way's contents mean anything, so the arrays can map to plain RAM.
    if (state == MEM_FILL && bus.mem_rsp_valid) line_buf[beat_cnt] <= bus.mem_rsp_data;
    if (state == REFILL) begin
      tag_arr[evicted_cl]  <= tag_q;
      data_arr[evicted_cl] <= line_buf;
    end
  end

  // Lines are filled only on a miss, so two ways can never hold one tag
  a_single_hit: assert property (@(posedge clk) disable iff (!rst)
    !(state == IDLE && bus.req_valid && cmp_multi));

`ifdef IFU_CACHE_PERF_EN
  // Saturating hit/miss counters, stepped on each lookup decision
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_hit_cnt  <= '0;
      perf_miss_cnt <= '0;
    end else if (state == LOOKUP) begin
      if (lookup_hit) perf_hit_cnt  <= sat_inc(perf_hit_cnt);
      else            perf_miss_cnt <= sat_inc(perf_miss_cnt);
    end
  end
`endif

endmodule
